// File: rtl/fifo_to_axi.sv
// fifo_to_axi: unpacks 201-bit FWFT FIFO entries into 256-bit AXI4-Stream beats.
// Four entries (phase 0..3) carry three words; tuser is popped once per packet.
module fifo_to_axi #(
    parameter int TDATA_WIDTH   = 32,
    parameter int TUSER_WIDTH   = 128,
    parameter int FIFO_WIDTH    = 201,
    parameter int PAYLOAD_WIDTH = 192
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     enable,
    input  logic [FIFO_WIDTH-1:0]    fifo_dout,
    input  logic                     fifo_empty,
    output logic                     fifo_rd_en,
    input  logic [TUSER_WIDTH-1:0]   tuser_dout,
    input  logic                     tuser_empty,
    output logic                     tuser_rd_en,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [TDATA_WIDTH*8-1:0] m_tdata,
    output logic [TDATA_WIDTH-1:0]   m_tkeep,
    output logic [TDATA_WIDTH-1:0]   m_tstrb,
    output logic                     m_tlast,
    output logic [TUSER_WIDTH-1:0]   m_tuser,
    output logic [31:0]              output_fifo_cnt,
    output logic                     framing_err
);

    localparam int DW = TDATA_WIDTH * 8;

    typedef enum logic {
        RUN    = 1'b0,
        RESYNC = 1'b1
    } mode_t;

    mode_t                    mode;
    logic [1:0]               exp_phase;
    logic                     first_pend;
    logic [PAYLOAD_WIDTH-1:0] stash;

    // Head entry fields
    logic [PAYLOAD_WIDTH-1:0] h_pay;
    logic [4:0]               h_code;
    logic [1:0]               h_phase;
    logic                     h_last;
    logic                     h_valid;

    assign h_pay   = fifo_dout[FIFO_WIDTH-1:9];
    assign h_code  = fifo_dout[8:4];
    assign h_phase = fifo_dout[3:2];
    assign h_last  = fifo_dout[1];
    assign h_valid = fifo_dout[0];

    logic present;
    logic out_free;
    logic h_sync;
    logic h_err;
    logic h_complete;

    assign present    = resetn & enable & ~fifo_empty;
    assign out_free   = ~m_tvalid | m_tready;
    assign h_sync     = h_valid & (h_phase == 2'd0) & ~h_last;
    assign h_complete = (h_phase != 2'd0);
    assign h_err      = (h_phase != exp_phase)
                      | ((h_phase == 2'd0) & h_last);

    logic pop;
    logic tpop;
    logic emit;
    logic advance;
    logic err;
    logic resync_exit;

    // Per-cycle decision: pop, discard, emit, flag error or leave resync
    always_comb begin
        pop         = 1'b0;
        tpop        = 1'b0;
        emit        = 1'b0;
        advance     = 1'b0;
        err         = 1'b0;
        resync_exit = 1'b0;
        if (present) begin
            if (mode == RESYNC) begin
                if (h_sync) resync_exit = 1'b1;
                else        pop         = 1'b1;
            end else if (!h_valid) begin
                pop = 1'b1;
            end else if (h_err) begin
                err = 1'b1;
            end else if (!h_complete) begin
                pop     = 1'b1;
                advance = 1'b1;
            end else if (out_free && (!first_pend || !tuser_empty)) begin
                pop     = 1'b1;
                emit    = 1'b1;
                advance = 1'b1;
                tpop    = first_pend;
            end
        end
    end

    assign fifo_rd_en  = pop;
    assign tuser_rd_en = tpop;

    logic [DW-1:0]            word;
    logic [PAYLOAD_WIDTH-1:0] stash_nx;
    logic [TDATA_WIDTH-1:0]   keep;

    // Word assembly from stash and head payload, indexed by phase
    always_comb begin
        word     = '0;
        stash_nx = stash;
        unique case (h_phase)
            2'd0: stash_nx = h_pay;
            2'd1: begin
                word     = {h_pay[63:0], stash};
                stash_nx = {64'd0, h_pay[191:64]};
            end
            2'd2: begin
                word     = {h_pay[127:0], stash[127:0]};
                stash_nx = {128'd0, h_pay[191:128]};
            end
            2'd3: begin
                word     = {h_pay, stash[63:0]};
                stash_nx = '0;
            end
        endcase
    end

    // Byte keep: partial only on the last beat with a nonzero code
    always_comb begin
        keep = '1;
        if (h_last && h_code != 5'd0)
            keep = (TDATA_WIDTH'(1) << h_code) - TDATA_WIDTH'(1);
    end

    // Output beat register and AXI handshake
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
        end else if (emit) begin
            m_tvalid <= 1'b1;
            m_tdata  <= word;
            m_tkeep  <= keep;
            m_tlast  <= h_last;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

    assign m_tstrb = m_tkeep;

    // Packet tuser, latched on the first beat of each packet
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)   m_tuser <= '0;
        else if (tpop) m_tuser <= tuser_dout;
    end

    // Accepted-beat counter, wraps naturally
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            output_fifo_cnt <= '0;
        else if (m_tvalid && m_tready)
            output_fifo_cnt <= output_fifo_cnt + 32'd1;
    end

    // Framing FSM: expected phase, run/resync mode, stash, sticky error
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode        <= RUN;
            exp_phase   <= 2'd0;
            first_pend  <= 1'b1;
            stash       <= '0;
            framing_err <= 1'b0;
        end else begin
            if (err) begin
                framing_err <= 1'b1;
                mode        <= RESYNC;
            end
            if (resync_exit) begin
                mode       <= RUN;
                exp_phase  <= 2'd0;
                first_pend <= 1'b1;
                stash      <= '0;
            end
            if (advance) begin
                stash <= stash_nx;
                if (emit && h_last) exp_phase <= 2'd0;
                else                exp_phase <= exp_phase + 2'd1;
                if (emit) first_pend <= h_last;
            end
        end
    end

endmodule
